mdu_32b: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS execute stage, implementing MULT, MULTU, DIV and DIVU and owning the architectural HI/LO registers. Each iteration step runs through the existing `add_sub_32b` adder/subtractor: add for shift-add multiply, subtract for restoring division. The unit sits beside the ALU, is started by the execute stage, and stalls the pipeline through `busy`. MFHI/MFLO read `hi`/`lo` directly; MTHI/MTLO write through dedicated enables.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/add_sub_32b.sv | 16 +
 rtl/mdu_32b.sv | 183 ++++++++++++++++++
 tb/tb_mdu_32b.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Two's-complement negation, kept local so the iteration adder stays dedicated.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/add_sub_32b.sv
// 32-bit adder/subtractor: o_sum = a + b (c_in=0) or a - b (c_in=1).
// Latency: combinational.
// Backpressure: none.
module add_sub_32b (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_c_in,
  output logic [31:0] o_sum
);

  logic [31:0] w_b_eff;

  assign w_b_eff = i_b ^ {32{i_c_in}};
  assign o_sum   = i_a + w_b_eff + {31'd0, i_c_in};

endmodule

// File: rtl/mdu_32b.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one radix-2 step per cycle.
// Latency: fixed 33 cycles from accepted start to done/HI/LO update.
// Backpressure: busy high while running; start and MTHI/MTLO ignored while busy.
module mdu_32b
  import mdu_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [31:0] i_wr_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  mdu_state_e  r_state;
  mdu_op_e     r_op;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc_hi;   // product upper half / partial remainder
  logic [31:0] r_acc_lo;   // product lower half / quotient
  logic [31:0] r_opa;      // |multiplicand| or |divisor|
  logic [31:0] r_opb;      // |multiplier| (shifts right) or |dividend| (shifts left)
  logic [31:0] r_raw_a;    // unconverted src_a, returned in HI on divide by zero
  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_div0;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Operand conditioning at start time
  logic        w_in_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  assign w_in_signed = ~i_op[0];
  assign w_abs_a     = (w_in_signed && i_src_a[31]) ? neg32(i_src_a) : i_src_a;
  assign w_abs_b     = (w_in_signed && i_src_b[31]) ? neg32(i_src_b) : i_src_b;

  // Iteration datapath through the shared adder
  logic        w_is_div;
  logic [31:0] w_div_shift;
  logic [31:0] w_add_a;
  logic [31:0] w_b_eff;
  logic [31:0] w_sum;
  logic        w_carry;
  logic        w_rem_ok;

  assign w_is_div    = r_op[1];
  assign w_div_shift = {r_acc_hi[30:0], r_opb[31]};
  assign w_add_a     = w_is_div ? w_div_shift : r_acc_hi;
  assign w_b_eff     = r_opa ^ {32{w_is_div}};

  add_sub_32b u_add_sub (
    .i_a    (w_add_a),
    .i_b    (r_opa),
    .i_c_in (w_is_div),
    .o_sum  (w_sum)
  );

  // Carry out of bit 31; when subtracting it is the "no borrow" flag.
  assign w_carry  = (w_add_a[31] & w_b_eff[31]) | ((w_add_a[31] | w_b_eff[31]) & ~w_sum[31]);
  // Bit shifted out of the remainder counts as the 33rd bit of the partial remainder.
  assign w_rem_ok = r_acc_hi[31] | w_carry;

  logic [32:0] w_mul_hi;
  logic [31:0] w_acc_hi_nx;
  logic [31:0] w_acc_lo_nx;
  logic [31:0] w_opb_nx;

  // Next accumulator state for one multiply or divide step
  always_comb begin
    w_mul_hi    = r_opb[0] ? {w_carry, w_sum} : {1'b0, r_acc_hi};
    w_acc_hi_nx = w_mul_hi[32:1];
    w_acc_lo_nx = {w_mul_hi[0], r_acc_lo[31:1]};
    w_opb_nx    = {1'b0, r_opb[31:1]};
    if (w_is_div) begin
      w_acc_hi_nx = w_rem_ok ? w_sum : w_div_shift;
      w_acc_lo_nx = {r_acc_lo[30:0], w_rem_ok};
      w_opb_nx    = {r_opb[30:0], 1'b0};
    end
  end

  // Sign fix-up and final HI/LO selection
  logic        w_signed;
  logic [63:0] w_prod;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_signed = ~r_op[0];

  always_comb begin
    w_prod = {r_acc_hi, r_acc_lo};
    if (w_signed && (r_sign_a ^ r_sign_b)) begin
      w_prod = neg64(w_prod);
    end
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (w_is_div) begin
      if (r_div0) begin
        w_res_hi = r_raw_a;
        w_res_lo = 32'hFFFF_FFFF;
      end else begin
        w_res_hi = (w_signed && r_sign_a) ? neg32(r_acc_hi) : r_acc_hi;
        w_res_lo = (w_signed && (r_sign_a ^ r_sign_b)) ? neg32(r_acc_lo) : r_acc_lo;
      end
    end
  end

  // Control FSM with registered busy/done and architectural HI/LO
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_op     <= MULT;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_raw_a  <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_op     <= mdu_op_e'(i_op);
            r_opa    <= i_op[1] ? w_abs_b : w_abs_a;
            r_opb    <= i_op[1] ? w_abs_a : w_abs_b;
            r_raw_a  <= i_src_a;
            r_sign_a <= i_src_a[31];
            r_sign_b <= i_src_b[31];
            r_div0   <= i_op[1] && (i_src_b == 32'd0);
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            if (i_hi_we) r_hi <= i_wr_data;
            if (i_lo_we) r_lo <= i_wr_data;
          end
        end
        RUN: begin
          r_acc_hi <= w_acc_hi_nx;
          r_acc_lo <= w_acc_lo_nx;
          r_opb    <= w_opb_nx;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'(ITER - 1)) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_32b.sv
// Scoreboard bench for mdu_32b: directed vectors, decoupled done monitor.
module tb_mdu_32b;
  import mdu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_src_a = '0;
  logic [31:0] i_src_b = '0;
  logic        i_hi_we = 1'b0;
  logic        i_lo_we = 1'b0;
  logic [31:0] i_wr_data = '0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  mdu_32b dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_src_a   (i_src_a),
    .i_src_b   (i_src_b),
    .i_hi_we   (i_hi_we),
    .i_lo_we   (i_lo_we),
    .i_wr_data (i_wr_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_issued = 0;
  int   n_done = 0;

  always @(posedge i_clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest pending expectation
  always @(negedge i_clk) begin
    if (!i_rst && o_done) begin
      if (sb.size() == 0) begin
        n_chk = n_chk + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_done: done seen with no pending op at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        n_done = n_done + 1;
        chk("hi", o_hi, mon_e.hi);
        chk("lo", o_lo, mon_e.lo);
        chk("latency", 32'(cyc - mon_e.edge_n), 32'd33);
        chk("busy_at_done", {31'd0, o_busy}, 32'd0);
      end
    end
  end

  // Called at a negedge with the unit idle; returns one negedge later.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    exp_t e;
    i_op    = op;
    i_src_a = a;
    i_src_b = b;
    i_start = 1'b1;
    e.hi     = exp_hi;
    e.lo     = exp_lo;
    e.edge_n = cyc + 1;
    sb.push_back(e);
    n_issued = n_issued + 1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk = n_chk + 1;
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL timeout: busy still %b after 40 cycles, required 0", o_busy);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b, exp_hi, exp_lo);
    wait_idle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_hi"}, o_hi, 32'd0);
    chk({tag, "_lo"}, o_lo, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    chk_zero("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Arithmetic vectors
    run(MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run(DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run(DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
    run(DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run(DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);

    // start and lo_we pulsed mid-operation must be ignored
    issue(MULTU, 32'd6, 32'd7, 32'd0, 32'd42);
    repeat (8) @(negedge i_clk);
    i_start   = 1'b1;
    i_op      = DIV;
    i_src_a   = 32'd1;
    i_src_b   = 32'd1;
    i_lo_we   = 1'b1;
    i_wr_data = 32'h0000_1234;
    @(negedge i_clk);
    i_start = 1'b0;
    i_lo_we = 1'b0;
    chk("busy_mid_op", {31'd0, o_busy}, 32'd1);
    chk("lo_we_while_busy", o_lo, 32'h0FFF_FFFF);
    wait_idle();

    // MTHI/MTLO in IDLE
    i_hi_we   = 1'b1;
    i_lo_we   = 1'b1;
    i_wr_data = 32'h0000_1234;
    @(negedge i_clk);
    i_hi_we = 1'b0;
    i_lo_we = 1'b0;
    chk("mthi_idle", o_hi, 32'h0000_1234);
    chk("mtlo_idle", o_lo, 32'h0000_1234);

    // start wins over a same-cycle write
    i_lo_we   = 1'b1;
    i_wr_data = 32'h0000_DEAD;
    issue(MULTU, 32'd3, 32'd5, 32'd0, 32'd15);
    i_lo_we = 1'b0;
    chk("write_dropped", o_lo, 32'h0000_1234);
    wait_idle();

    // Reset in the middle of a divide
    issue(DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    repeat (13) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk_zero("midop_reset");
    void'(sb.pop_back());
    n_issued = n_issued - 1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    run(MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (5) @(negedge i_clk);
    chk("pending_ops", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_issued));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
